// File: rtl/fpadd_operand_swap_pipe_pkg.sv
// Shared widths, field offsets and the S2 result bundle for the FP add/sub
// operand-swap front end.
package fpu_addsub_pkg;

  localparam int W  = 32;
  localparam int EW = 8;
  localparam int SW = 23;

  localparam int SGN_BIT = W - 1;
  localparam int EXP_MSB = W - 2;
  localparam int EXP_LSB = SW;
  localparam int MAN_MSB = SW - 1;
  localparam int MAN_LSB = 0;

  typedef struct packed {
    logic [W-1:0]  dmp;
    logic [W-1:0]  dmnp;
    logic [EW-1:0] exp_diff;
    logic          eff_op;
    logic          sgn_result;
    logic          zero_res;
  } swap_bundle_t;

endpackage

// File: rtl/fpadd_operand_swap_pipe_if.sv
// Valid/ready handshake and operand/result bus of the operand-swap pipeline.
interface fpadd_operand_swap_pipe_if;
  import fpu_addsub_pkg::*;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_x;
  logic [W-1:0]  data_y;
  logic          add_subt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dmp;
  logic [W-1:0]  dmnp;
  logic [EW-1:0] exp_diff;
  logic          eff_op;
  logic          sgn_result;
  logic          zero_res;

  modport master (
    output flush, in_valid, data_x, data_y, add_subt, out_ready,
    input  in_ready, out_valid, dmp, dmnp, exp_diff, eff_op, sgn_result, zero_res
  );

  modport slave (
    input  flush, in_valid, data_x, data_y, add_subt, out_ready,
    output in_ready, out_valid, dmp, dmnp, exp_diff, eff_op, sgn_result, zero_res
  );

endinterface

// File: rtl/fpadd_operand_swap_pipe_mag_cmp.sv
// Unsigned magnitude comparator over the exponent+fraction bits of two operands.
module fp_mag_comparator #(
  parameter int N = 31
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt,
  output logic         eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/fpadd_operand_swap_pipe.sv
// Two-stage valid/ready front end of the FP adder: orders operands by magnitude,
// forms the exponent difference and resolves effective op, sign and exact zero.
module fpadd_operand_swap_pipe
  import fpu_addsub_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  fpadd_operand_swap_pipe_if.slave  bus
);

  logic         vld_p1, vld_p2;
  logic [W-1:0] x_p1, y_p1;
  logic         op_p1, gt_p1, eq_p1;
  logic         gt_in, eq_in;
  logic         s1_load, s2_load;
  logic         sy_eff, y_bigger;
  swap_bundle_t res_nxt, res_p2;

  // Equal magnitudes of opposite effective sign cancel to +0.
  function automatic logic result_sign(input logic gt, input logic eq,
                                       input logic sx, input logic sy_e);
    if (gt)              return sx;
    else if (!eq)        return sy_e;
    else if (sx == sy_e) return sx;
    else                 return 1'b0;
  endfunction

  assign s2_load     = ~vld_p2 | bus.out_ready;
  assign s1_load     = ~vld_p1 | s2_load;
  assign bus.in_ready = s1_load;

  fp_mag_comparator #(.N(W-1)) u_mag_cmp (
    .a  (bus.data_x[W-2:0]),
    .b  (bus.data_y[W-2:0]),
    .gt (gt_in),
    .eq (eq_in)
  );

  // ---- S1 -> S2 boundary: swap, exponent difference, sign/zero decision ----
  always_comb begin
    res_nxt  = '0;
    sy_eff   = y_p1[SGN_BIT] ^ op_p1;
    y_bigger = ~gt_p1 & ~eq_p1;
    res_nxt.dmp        = y_bigger ? y_p1 : x_p1;
    // The minor operand carries Y's effective sign when it is Y.
    res_nxt.dmnp       = y_bigger ? x_p1 : {sy_eff, y_p1[W-2:0]};
    res_nxt.exp_diff   = res_nxt.dmp[EXP_MSB:EXP_LSB] - res_nxt.dmnp[EXP_MSB:EXP_LSB];
    res_nxt.eff_op     = op_p1 ^ x_p1[SGN_BIT] ^ y_p1[SGN_BIT];
    res_nxt.sgn_result = result_sign(gt_p1, eq_p1, x_p1[SGN_BIT], sy_eff);
    res_nxt.zero_res   = eq_p1 & res_nxt.eff_op;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
      op_p1  <= 1'b0;
      gt_p1  <= 1'b0;
      eq_p1  <= 1'b0;
      res_p2 <= '0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      // ---- S2 register ----
      if (s2_load) begin
        vld_p2 <= vld_p1;
        if (vld_p1) res_p2 <= res_nxt;
      end
      // ---- S1 register ----
      if (s1_load) begin
        vld_p1 <= bus.in_valid;
        if (bus.in_valid) begin
          x_p1  <= bus.data_x;
          y_p1  <= bus.data_y;
          op_p1 <= bus.add_subt;
          gt_p1 <= gt_in;
          eq_p1 <= eq_in;
        end
      end
    end
  end

  assign bus.out_valid  = vld_p2;
  assign bus.dmp        = res_p2.dmp;
  assign bus.dmnp       = res_p2.dmnp;
  assign bus.exp_diff   = res_p2.exp_diff;
  assign bus.eff_op     = res_p2.eff_op;
  assign bus.sgn_result = res_p2.sgn_result;
  assign bus.zero_res   = res_p2.zero_res;

endmodule

// File: tb/tb_fpadd_operand_swap_pipe.sv
// Table-driven and scoreboard bench for the FP add/sub operand-swap pipeline.
module tb_fpadd_operand_swap_pipe;
  import fpu_addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpadd_operand_swap_pipe_if bus();

  fpadd_operand_swap_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]  x;
    logic [31:0]  y;
    logic         op;
    swap_bundle_t exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  swap_bundle_t sb[$];
  swap_bundle_t cur_exp;
  swap_bundle_t held;
  logic         stall_chk = 1'b0;
  logic         saw_not_ready = 1'b0;

  function automatic swap_bundle_t mk(input logic [31:0] dmp, input logic [31:0] dmnp,
                                      input logic [7:0] ed, input logic eff,
                                      input logic sgn, input logic zero);
    swap_bundle_t b;
    b.dmp = dmp; b.dmnp = dmnp; b.exp_diff = ed;
    b.eff_op = eff; b.sgn_result = sgn; b.zero_res = zero;
    return b;
  endfunction

  function automatic swap_bundle_t model(input logic [31:0] x, input logic [31:0] y,
                                         input logic op);
    swap_bundle_t b;
    logic [30:0] mx, my;
    logic sx, sy, sye;
    mx = x[30:0]; my = y[30:0]; sx = x[31]; sy = y[31]; sye = sy ^ op;
    if (my > mx) begin
      b.dmp = y; b.dmnp = x; b.sgn_result = sye;
    end else begin
      b.dmp = x; b.dmnp = {sye, y[30:0]};
      if (mx > my)       b.sgn_result = sx;
      else if (sx == sye) b.sgn_result = sx;
      else               b.sgn_result = 1'b0;
    end
    b.exp_diff = b.dmp[30:23] - b.dmnp[30:23];
    b.eff_op   = op ^ sx ^ sy;
    b.zero_res = (mx == my) && b.eff_op;
    return b;
  endfunction

  function automatic swap_bundle_t cur_out();
    return mk(bus.dmp, bus.dmnp, bus.exp_diff, bus.eff_op, bus.sgn_result, bus.zero_res);
  endfunction

  task automatic chk(input string name, input logic ok,
                     input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (stall_chk) begin
        n_checks++;
        if (!(bus.out_valid && cur_out() == held)) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b %h, expected v=1 %h", bus.out_valid, cur_out(), held);
        end
      end
      if (bus.in_valid && !bus.in_ready) saw_not_ready = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected: got %h, expected no output", cur_out());
        end else begin
          swap_bundle_t e;
          e = sb.pop_front();
          n_checks++;
          if (cur_out() != e) begin
            n_fail++;
            $display("FAIL sb_out: got dmp=%h dmnp=%h ed=%0d eff=%b sgn=%b zero=%b, expected dmp=%h dmnp=%h ed=%0d eff=%b sgn=%b zero=%b",
                     bus.dmp, bus.dmnp, bus.exp_diff, bus.eff_op, bus.sgn_result, bus.zero_res,
                     e.dmp, e.dmnp, e.exp_diff, e.eff_op, e.sgn_result, e.zero_res);
          end
        end
      end
      if (bus.flush) sb.delete();
      else if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
      stall_chk = bus.out_valid && !bus.out_ready && !bus.flush;
      held = cur_out();
    end else begin
      stall_chk = 1'b0;
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic op,
                      input swap_bundle_t e);
    int n;
    bus.data_x = x; bus.data_y = y; bus.add_subt = op; cur_exp = e;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
        $fatal(1, "input handshake stuck");
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", n < 200, 128'(sb.size()), 128'd0);
  endtask

  vec_t vecs[10];
  logic done;

  initial begin
    vecs[0] = '{32'h40400000, 32'h3F800000, 1'b1, mk(32'h40400000, 32'hBF800000, 8'd1, 1, 0, 0)};
    vecs[1] = '{32'h3F800000, 32'h40400000, 1'b1, mk(32'h40400000, 32'h3F800000, 8'd1, 1, 1, 0)};
    vecs[2] = '{32'h40000000, 32'h40000000, 1'b1, mk(32'h40000000, 32'hC0000000, 8'd0, 1, 0, 1)};
    vecs[3] = '{32'hC0000000, 32'h40000000, 1'b1, mk(32'hC0000000, 32'hC0000000, 8'd0, 0, 1, 0)};
    vecs[4] = '{32'h40400000, 32'hBF800000, 1'b0, mk(32'h40400000, 32'hBF800000, 8'd1, 1, 0, 0)};
    vecs[5] = '{32'h3F800000, 32'hC1200000, 1'b0, mk(32'hC1200000, 32'h3F800000, 8'd3, 1, 1, 0)};
    vecs[6] = '{32'h7F800000, 32'h00000001, 1'b0, mk(32'h7F800000, 32'h00000001, 8'd255, 0, 0, 0)};
    vecs[7] = '{32'h80000000, 32'h00000000, 1'b0, mk(32'h80000000, 32'h00000000, 8'd0, 1, 0, 1)};
    vecs[8] = '{32'h3F800001, 32'h3F800000, 1'b1, mk(32'h3F800001, 32'hBF800000, 8'd0, 1, 0, 0)};
    vecs[9] = '{32'h3F800000, 32'h3F800001, 1'b0, mk(32'h3F800001, 32'h3F800000, 8'd0, 0, 0, 0)};

    bus.flush = 0; bus.in_valid = 0; bus.data_x = 0; bus.data_y = 0;
    bus.add_subt = 0; bus.out_ready = 1; cur_exp = '0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", bus.out_valid == 1'b0, 128'(bus.out_valid), 128'd0);
    chk("rst_dmp", bus.dmp == 32'd0, 128'(bus.dmp), 128'd0);
    chk("rst_dmnp", bus.dmnp == 32'd0, 128'(bus.dmnp), 128'd0);
    chk("rst_exp_diff", bus.exp_diff == 8'd0, 128'(bus.exp_diff), 128'd0);
    chk("rst_flags", {bus.eff_op, bus.sgn_result, bus.zero_res} == 3'b000,
        128'({bus.eff_op, bus.sgn_result, bus.zero_res}), 128'd0);
    chk("rst_ready", bus.in_ready == 1'b1, 128'(bus.in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back to back
    for (int i = 0; i < 10; i++) send(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].exp);
    drain();

    // Four-op stream with downstream stall for three cycles
    saw_not_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(32'h40800000 + 32'(i), 32'h3F000000 + 32'(i << 23), 1'b0,
               model(32'h40800000 + 32'(i), 32'h3F000000 + 32'(i << 23), 1'b0));
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_backpressure", saw_not_ready == 1'b1, 128'(saw_not_ready), 128'd1);

    // Asynchronous reset with two operations in flight
    send(32'h41000000, 32'h40000000, 1'b0, model(32'h41000000, 32'h40000000, 1'b0));
    send(32'h42000000, 32'h40000000, 1'b1, model(32'h42000000, 32'h40000000, 1'b1));
    chk("pre_rst_valid", bus.out_valid == 1'b1, 128'(bus.out_valid), 128'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_valid", bus.out_valid == 1'b0, 128'(bus.out_valid), 128'd0);
    chk("rst_async_dmp", bus.dmp == 32'd0, 128'(bus.dmp), 128'd0);
    sb.delete();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    send(32'hC0A00000, 32'h40400000, 1'b1, model(32'hC0A00000, 32'h40400000, 1'b1));
    @(negedge clk);
    chk("lat_after_1", bus.out_valid == 1'b0, 128'(bus.out_valid), 128'd0);
    @(posedge clk); #1;
    chk("lat_after_2", bus.out_valid == 1'b1, 128'(bus.out_valid), 128'd1);
    drain();

    // Flush with an input offered on a full pipe
    bus.out_ready = 1'b0;
    send(32'h40000000, 32'h3F800000, 1'b0, model(32'h40000000, 32'h3F800000, 1'b0));
    send(32'h40400000, 32'h3F800000, 1'b0, model(32'h40400000, 32'h3F800000, 1'b0));
    chk("full_ready", bus.in_ready == 1'b0, 128'(bus.in_ready), 128'd0);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    bus.data_x = 32'h45000000; bus.data_y = 32'h3F800000; bus.add_subt = 1'b0;
    cur_exp = model(32'h45000000, 32'h3F800000, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_valid", bus.out_valid == 1'b0, 128'(bus.out_valid), 128'd0);
    chk("flush_ready", bus.in_ready == 1'b1, 128'(bus.in_ready), 128'd1);
    repeat (3) @(posedge clk);
    #1 chk("flush_no_accept", bus.out_valid == 1'b0, 128'(bus.out_valid), 128'd0);

    // Random stream with random downstream back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] x, y;
          logic op;
          x = $urandom; y = $urandom; op = 1'($urandom);
          case ($urandom_range(0, 3))
            0: y = {y[31], x[30:0]};
            1: y = {y[31], x[30:23], y[22:0]};
            default: ;
          endcase
          send(x, y, op, model(x, y, op));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
